adder_tree_arbiter: RTL and testbench

ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

---
 rtl/adder_tree_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/adder_tree_arbiter.sv | 119 +++++++++++
 tb/tb_adder_tree_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants for the adder-tree arbiter. Tree depth depends on
// the ADDER_TREE_FULL_SUM_EN macro (3 levels when defined, else 2).
package adder_tree_pkg;

   localparam int OP_COUNT = 8;

`ifdef ADDER_TREE_FULL_SUM_EN
   localparam int TREE_LEVELS = 3;
`else
   localparam int TREE_LEVELS = 2;
`endif

   localparam int TREE_OPS = 1 << TREE_LEVELS;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among asserted requests, starting the
// search at the rotating priority pointer; pointer moves past each winner.
module rr_arbiter
   import adder_tree_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IW = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      gnt_idx
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic          found;

   // NUM_REQ is a power of two, so IW-bit addition wraps the search index.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IW'(int'(ptr) + i);
         if (accept && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (|gnt)
         ptr <= gnt_idx + 1'b1;
   end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbitrated 2-stage adder tree (S1: operands, S2: sum).
// Define ADDER_TREE_FULL_SUM_EN to sum all 8 operands instead of 0..3.
module adder_tree_arbiter
   import adder_tree_pkg::*;
#(
   parameter int ADDER_WIDTH = 12,
   parameter int NUM_REQ     = 4,
   localparam int IW         = id_width(NUM_REQ),
   localparam int SUM_W      = ADDER_WIDTH + TREE_LEVELS
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req,
   input  logic [NUM_REQ*OP_COUNT*ADDER_WIDTH-1:0] op,
   output logic [NUM_REQ-1:0]                    gnt,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [IW-1:0]                         out_id,
   output logic [SUM_W-1:0]                      out_sum
);

   logic                   adv_p1;
   logic                   accept;
   logic [IW-1:0]          id_p0;
   logic [ADDER_WIDTH-1:0] opnd_p0 [TREE_OPS];

   logic                   vld_p1;
   logic [IW-1:0]          id_p1;
   logic [ADDER_WIDTH-1:0] opnd_p1 [TREE_OPS];
   logic [SUM_W-1:0]       sum_p1;

   logic                   vld_p2;
   logic [IW-1:0]          id_p2;
   logic [SUM_W-1:0]       sum_p2;

   assign adv_p1 = !vld_p2 || out_ready;
   assign accept = !rst && (!vld_p1 || adv_p1);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .accept  (accept),
      .gnt     (gnt),
      .gnt_idx (id_p0)
   );

   // Stage 0: select the winner's operands
   always_comb begin
      for (int k = 0; k < TREE_OPS; k++)
         opnd_p0[k] = op[(int'(id_p0) * OP_COUNT + k) * ADDER_WIDTH +: ADDER_WIDTH];
   end

`ifndef ADDER_TREE_FULL_SUM_EN
   logic unused_op;
   always_comb begin
      unused_op = 1'b0;
      for (int r = 0; r < NUM_REQ; r++)
         for (int k = TREE_OPS; k < OP_COUNT; k++)
            unused_op = unused_op ^ (^op[(r * OP_COUNT + k) * ADDER_WIDTH +: ADDER_WIDTH]);
   end
`endif

   // Stage 1: granted operands and id
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (accept)
         vld_p1 <= |gnt;
   end

   always_ff @(posedge clk) begin
      if (|gnt) begin
         id_p1 <= id_p0;
         for (int k = 0; k < TREE_OPS; k++)
            opnd_p1[k] <= opnd_p0[k];
      end
   end

   // Zero-extended tree, each level one bit wider than its inputs
`ifdef ADDER_TREE_FULL_SUM_EN
   logic [ADDER_WIDTH:0]   lvl1 [4];
   logic [ADDER_WIDTH+1:0] lvl2 [2];
   always_comb begin
      for (int i = 0; i < 4; i++)
         lvl1[i] = {1'b0, opnd_p1[2*i]} + {1'b0, opnd_p1[2*i+1]};
      for (int i = 0; i < 2; i++)
         lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
      sum_p1 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
   end
`else
   logic [ADDER_WIDTH:0]   lvl1 [2];
   always_comb begin
      for (int i = 0; i < 2; i++)
         lvl1[i] = {1'b0, opnd_p1[2*i]} + {1'b0, opnd_p1[2*i+1]};
      sum_p1 = {1'b0, lvl1[0]} + {1'b0, lvl1[1]};
   end
`endif

   // Stage 2: registered result, held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         id_p2  <= '0;
         sum_p2 <= '0;
      end else if (adv_p1) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            id_p2  <= id_p1;
            sum_p2 <= sum_p1;
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_id    = id_p2;
   assign out_sum   = sum_p2;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Randomized bench for adder_tree_arbiter with a slot-level reference model
// plus directed scenarios pinned by hand-computed values.
module tb_adder_tree_arbiter;

   localparam int AW = 12;
   localparam int N  = 4;
   localparam int IW = 2;
`ifdef ADDER_TREE_FULL_SUM_EN
   localparam int NOPS    = 8;
   localparam int SW      = AW + 3;
   localparam int EXP_T1  = 36;
   localparam int EXP_MAX = 32760;
`else
   localparam int NOPS    = 4;
   localparam int SW      = AW + 2;
   localparam int EXP_T1  = 10;
   localparam int EXP_MAX = 16380;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N*8*AW-1:0] op = '0;
   logic [N-1:0]      gnt;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [IW-1:0]     out_id;
   logic [SW-1:0]     out_sum;

   adder_tree_arbiter #(.ADDER_WIDTH(AW), .NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op        (op),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_sum   (out_sum)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int delivered[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int opsum(input int r);
      int s = 0;
      for (int k = 0; k < NOPS; k++)
         s += int'(op[(r*8+k)*AW +: AW]);
      return s;
   endfunction

   // Reference model: two result slots (operands-held, result-held) and a pointer
   bit m1_v, m2_v;
   int m1_id, m2_id, m1_sum, m2_sum, m_ptr;

   always @(negedge clk) begin
      bit adv, can, found;
      int gid;
      logic [N-1:0] eg;
      if (rst) begin
         m1_v = 0; m2_v = 0; m_ptr = 0;
         chk("rst_gnt", int'(gnt), 0);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_id", int'(out_id), 0);
         chk("rst_out_sum", int'(out_sum), 0);
      end else begin
         chk("out_valid", int'(out_valid), int'(m2_v));
         if (m2_v) begin
            chk("out_id", int'(out_id), m2_id);
            chk("out_sum", int'(out_sum), m2_sum);
         end
         adv = !m2_v || out_ready;
         can = !m1_v || adv;
         eg = '0; found = 0; gid = 0;
         for (int i = 0; i < N; i++) begin
            int r;
            r = (m_ptr + i) % N;
            if (can && !found && req[r]) begin
               found = 1; gid = r; eg[r] = 1'b1;
            end
         end
         chk("gnt", int'(gnt), int'(eg));
         if (m2_v && out_ready) delivered.push_back(m2_id);
         if (adv) begin
            m2_v = m1_v; m2_id = m1_id; m2_sum = m1_sum;
         end
         if (can) begin
            m1_v = found;
            if (found) begin
               m1_id = gid; m1_sum = opsum(gid);
            end
         end
         if (found) m_ptr = (gid + 1) % N;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; out_ready = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N*8; i++)
         op[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
   endtask

   initial begin
      int base;
      logic [N-1:0] g;

      // Single requester, operands 1..8
      do_reset();
      rand_ops();
      for (int k = 0; k < 8; k++) op[(2*8+k)*AW +: AW] = AW'(k + 1);
      req = 4'b0100;
      #1 chk("t1_gnt", int'(gnt), 4);
      cyc(); req = '0;
      cyc();
      #1 chk("t1_valid", int'(out_valid), 1);
      chk("t1_id", int'(out_id), 2);
      chk("t1_sum", int'(out_sum), EXP_T1);
      cyc(); cyc();

      // All requesters held: grants rotate 0,1,2,3,0
      do_reset();
      rand_ops();
      base = delivered.size();
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         #1 chk("t2_gnt", int'(gnt), 1 << (j % N));
         cyc();
      end
      req = '0;
      repeat (4) cyc();
      for (int j = 0; j < 5; j++)
         chk("t2_order", (base + j < delivered.size()) ? delivered[base + j] : -1, j % N);

      // Maximum operands, no wrap
      do_reset();
      op = '1;
      req = 4'b0001;
      cyc(); req = '0;
      cyc();
      #1 chk("t3_valid", int'(out_valid), 1);
      chk("t3_sum", int'(out_sum), EXP_MAX);
      cyc(); cyc();

      // Back-pressure for 3 cycles with continuous requests
      do_reset();
      rand_ops();
      base = delivered.size();
      req = 4'b1111;
      repeat (3) cyc();
      out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1 chk("t4_gnt_stall", int'(gnt), 0);
         chk("t4_hold_id", int'(out_id), 1);
         chk("t4_hold_sum", int'(out_sum), opsum(1));
         cyc();
      end
      out_ready = 1'b1;
      repeat (2) cyc();
      req = '0;
      repeat (4) cyc();
      chk("t4_count", delivered.size() - base, 5);

      // Reset with two results in flight
      do_reset();
      rand_ops();
      req = 4'b1111;
      cyc(); cyc();
      rst = 1'b1;
      #1 chk("t5_valid_rst", int'(out_valid), 0);
      chk("t5_gnt_rst", int'(gnt), 0);
      cyc();
      rst = 1'b0; req = 4'b1010;
      #1 chk("t5_first_gnt", int'(gnt), 2);
      cyc(); req = 4'b1000;
      cyc(); req = '0;
      repeat (3) cyc();

      // New request while both stages full and the consumer accepts
      do_reset();
      rand_ops();
      req = 4'b0001;
      cyc(); out_ready = 1'b0;
      cyc(); req = '0;
      cyc(); req = 4'b0010; out_ready = 1'b1;
      #1 chk("t6_gnt_nobubble", int'(gnt), 2);
      cyc(); req = '0;
      repeat (3) cyc();

      // Randomized traffic; requests held until granted
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rand_ops();
         out_ready = ($urandom_range(0, 3) != 0);
         #3 g = gnt;
         cyc();
         req = (req & ~g) | N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1));
      end
      req = '0; out_ready = 1'b1;
      repeat (5) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
